// File: rtl/status_led_arbiter.sv
// ============================================================================
// status_led_arbiter : front-panel LED arbiter, error blink > activity > heartbeat
// Revision: 1.0
// ============================================================================
`default_nettype none

module status_led_arbiter #(
    parameter int TICK_DIV  = 2500000,
    parameter int ON_TICKS  = 10,
    parameter int OFF_TICKS = 10,
    parameter int GAP_TICKS = 40,
    parameter int ACT_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] hb_leds,
    input  logic       act_pulse,
    input  logic       err_req,
    input  logic [3:0] err_code,
    output logic       err_busy,
    output logic [1:0] leds
);

    localparam int PW     = $clog2(TICK_DIV) + 1;
    localparam int AW     = $clog2(ACT_TICKS) + 1;
    localparam int PH_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int FW     = $clog2(PH_MAX) + 1;

    localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] C_ON        = FW'(ON_TICKS);
    localparam logic [FW-1:0] C_OFF       = FW'(OFF_TICKS);
    localparam logic [FW-1:0] C_GAP       = FW'(GAP_TICKS);
    localparam logic [AW-1:0] C_ACT       = AW'(ACT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic [PW-1:0]   presc_q,  presc_d;
    logic [AW-1:0]   act_q,    act_d;
    logic [FW-1:0]   phase_q,  phase_d;
    logic [3:0]      blinks_q, blinks_d;
    logic [1:0]      leds_q,   leds_d;

    logic            w_tick;
    logic            w_start;
    logic            w_phase_last;

    assign w_tick       = (presc_q == C_TICK_LAST);
    assign w_start      = err_req && (err_code != 4'd0);
    // <=1 rather than ==1 so a stray zero count can never park the FSM
    assign w_phase_last = w_tick && (phase_q <= FW'(1));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        blinks_d = blinks_q;
        presc_d  = w_tick ? '0 : presc_q + PW'(1);

        if (act_pulse) begin
            act_d = C_ACT;
        end else if (w_tick && (act_q != '0)) begin
            act_d = act_q - AW'(1);
        end else begin
            act_d = act_q;
        end

        if (w_tick && (phase_q != '0)) begin
            phase_d = phase_q - FW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d  = ST_ON;
                    phase_d  = C_ON;
                    blinks_d = err_code;
                    presc_d  = '0;
                end
            end
            ST_ON: begin
                if (w_phase_last) begin
                    state_d = ST_OFF;
                    phase_d = C_OFF;
                end
            end
            ST_OFF: begin
                if (w_phase_last) begin
                    if (blinks_q > 4'd1) begin
                        state_d  = ST_ON;
                        phase_d  = C_ON;
                        blinks_d = blinks_q - 4'd1;
                    end else begin
                        state_d = ST_GAP;
                        phase_d = C_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Repeat starts on a tick boundary already, so the prescaler runs on
                if (w_phase_last) begin
                    if (w_start) begin
                        state_d  = ST_ON;
                        phase_d  = C_ON;
                        blinks_d = err_code;
                    end else begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        case (state_q)
            ST_ON:          leds_d = 2'b11;
            ST_OFF, ST_GAP: leds_d = 2'b00;
            default:        leds_d = (act_q != '0) ? 2'b01 : hb_leds;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            act_q    <= '0;
            phase_q  <= '0;
            blinks_q <= '0;
            leds_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            act_q    <= act_d;
            phase_q  <= phase_d;
            blinks_q <= blinks_d;
            leds_q   <= leds_d;
        end
    end

    assign err_busy = (state_q != ST_IDLE);
    assign leds     = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_status_led_arbiter.sv
// ============================================================================
// tb_status_led_arbiter : vector table, corner-case sequences and random run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_status_led_arbiter;

    localparam int TD   = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 2;
    localparam int GAPT = 4;
    localparam int ACTT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] hb_leds = 2'b00;
    logic       act_pulse = 1'b0;
    logic       err_req = 1'b0;
    logic [3:0] err_code = 4'd0;
    logic       err_busy;
    logic [1:0] leds;

    status_led_arbiter #(
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT),
        .GAP_TICKS(GAPT),
        .ACT_TICKS(ACTT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hb_leds  (hb_leds),
        .act_pulse(act_pulse),
        .err_req  (err_req),
        .err_code (err_code),
        .err_busy (err_busy),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an error display is a timeline indexed by cycles since
    // its start; activity is a count of ticks still to elapse.
    int         m_presc;
    int         m_act;
    int         m_off;
    int         m_code;
    bit         m_busy;
    logic [1:0] m_leds;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_act   = 0;
        m_off   = 0;
        m_code  = 0;
        m_busy  = 0;
        m_leds  = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] hb, input logic act, input logic req, input logic [3:0] code);
        bit tick;
        int win;
        tick = (m_presc == TD - 1);
        win  = (ONT + OFFT) * TD;
        if (m_busy)
            m_leds = (m_off < m_code * win && (m_off % win) < ONT * TD) ? 2'b11 : 2'b00;
        else
            m_leds = (m_act != 0) ? 2'b01 : hb;

        if (act)                   m_act = ACTT;
        else if (tick && m_act > 0) m_act = m_act - 1;

        if (!m_busy) begin
            if (req && code != 0) begin
                m_busy  = 1;
                m_off   = 0;
                m_code  = int'(code);
                m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % TD;
            end
        end else begin
            m_presc = (m_presc + 1) % TD;
            m_off   = m_off + 1;
            if (m_off == (m_code * (ONT + OFFT) + GAPT) * TD) begin
                if (req && code != 0) begin
                    m_off  = 0;
                    m_code = int'(code);
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [1:0] hb, input logic act, input logic req, input logic [3:0] code);
        hb_leds   = hb;
        act_pulse = act;
        err_req   = req;
        err_code  = code;
        @(posedge clk);
        model_edge(hb, act, req, code);
        @(negedge clk);
        check("model_leds", 32'(leds), 32'(m_leds));
        check("model_busy", 32'(err_busy), 32'(m_busy));
    endtask

    typedef struct {
        logic [1:0] hb;
        logic       act;
        logic       req;
        logic [3:0] code;
        logic [1:0] exp_leds;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int last01;
        int busy_cnt;
        int ones;
        int wins;
        int run;
        int zeros_busy;
        int cnt01;
        logic [1:0] prev;

        tbl[0] = '{2'b01, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0};
        tbl[1] = '{2'b10, 1'b0, 1'b0, 4'd0, 2'b10, 1'b0};
        tbl[2] = '{2'b01, 1'b0, 1'b1, 4'd0, 2'b01, 1'b0};
        tbl[3] = '{2'b10, 1'b1, 1'b0, 4'd0, 2'b10, 1'b0};
        tbl[4] = '{2'b10, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0};
        tbl[5] = '{2'b11, 1'b0, 1'b1, 4'd0, 2'b01, 1'b0};
        tbl[6] = '{2'b00, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0};
        tbl[7] = '{2'b11, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_busy", 32'(err_busy), 32'd0);
        rst_n = 1'b1;

        // Passthrough, zero-code request and start of an activity flash
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].hb, tbl[i].act, tbl[i].req, tbl[i].code);
            check($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
            check($sformatf("tbl%0d_busy", i), 32'(err_busy), 32'(tbl[i].exp_busy));
        end

        // Retrigger on edge 10; flash must hold through edge 20
        last01 = 0;
        for (int e = 9; e <= 26; e++) begin
            step(2'b10, (e == 10), 1'b0, 4'd0);
            if (leds == 2'b01) last01 = e;
        end
        check("act_stretch_end", 32'(last01), 32'd20);

        // Code 3, request pulsed one cycle
        step(2'b01, 1'b0, 1'b1, 4'd3);
        busy_cnt = err_busy ? 1 : 0;
        ones = 0; wins = 0; run = 0; prev = leds;
        for (int i = 1; i <= 80; i++) begin
            step(2'b01, 1'b0, 1'b0, 4'd0);
            if (err_busy) busy_cnt++;
            if (leds == 2'b11) begin
                ones++;
                run++;
                if (prev != 2'b11) wins++;
            end else if (prev == 2'b11) begin
                check("code3_window_len", 32'(run), 32'd8);
                run = 0;
            end
            prev = leds;
        end
        check("code3_busy_cycles", 32'(busy_cnt), 32'd64);
        check("code3_on_cycles", 32'(ones), 32'd24);
        check("code3_windows", 32'(wins), 32'd3);
        check("code3_idle_busy", 32'(err_busy), 32'd0);

        // Code changes 3->1 mid-sequence with request held: 3 blinks then 1
        step(2'b01, 1'b0, 1'b1, 4'd3);
        ones = 0; wins = 0; zeros_busy = 0; prev = leds;
        for (int i = 1; i <= 96; i++) begin
            step(2'b01, 1'b0, (i < 70), (i >= 20) ? 4'd1 : 4'd3);
            if (leds == 2'b11) begin
                ones++;
                if (prev != 2'b11) wins++;
            end
            if (i < 96 && !err_busy) zeros_busy++;
            if (i == 96) check("repeat_end_busy", 32'(err_busy), 32'd0);
            prev = leds;
        end
        check("repeat_on_cycles", 32'(ones), 32'd32);
        check("repeat_windows", 32'(wins), 32'd4);
        check("repeat_no_idle", 32'(zeros_busy), 32'd0);

        // Activity during OFF is masked and has expired by IDLE
        step(2'b10, 1'b0, 1'b1, 4'd1);
        cnt01 = 0;
        for (int i = 1; i <= 40; i++) begin
            step(2'b10, (i == 10), 1'b0, 4'd0);
            if (leds == 2'b01) cnt01++;
        end
        check("mask_off_no_act", 32'(cnt01), 32'd0);

        // Activity late in GAP survives into IDLE
        step(2'b10, 1'b0, 1'b1, 4'd1);
        for (int i = 1; i <= 40; i++) begin
            step(2'b10, (i == 30), 1'b0, 4'd0);
            if (i == 32) check("gap_act_masked", 32'(leds), 32'd0);
            if (i == 33) check("gap_act_visible", 32'(leds), 32'd1);
        end

        // Asynchronous reset while ON
        step(2'b01, 1'b0, 1'b1, 4'd2);
        repeat (4) step(2'b01, 1'b0, 1'b0, 4'd0);
        check("pre_reset_on", 32'(leds), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 32'd0);
        check("async_rst_busy", 32'(err_busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b10, 1'b0, 1'b0, 4'd0);
        check("post_reset_hb", 32'(leds), 32'd2);
        step(2'b01, 1'b0, 1'b0, 4'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(2'($urandom), ($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0),
                 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
